riscv_ex_pipe_slice: RTL and testbench
======================================

Name: riscv_ex_pipe_slice

Overview:
Parametrised, elastic replacement for the fixed single-register EX-to-EX stage hops in the execute pipeline. It holds DEPTH slots of one instruction payload each and applies valid/ready backpressure with bubble collapsing. It also supports a synchronous flush and an occupancy count. It provides NUM_FWD combinational forwarding lookups into the in-flight results, so EX-stage bypass needs no separate match logic.

Parameters:
XLEN, 64, data path width (32 or 64)
DEPTH, 2, number of register slots (1..8)
NUM_FWD, 2, number of forwarding query ports (1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-high
flush  in  1  kill all in-flight slots
in_valid  in  1  upstream payload valid
in_ready  out  1  slice can accept this cycle
in_pc  in  XLEN  instruction PC
in_inst  in  32  instruction word
in_result  in  XLEN  ALU result
in_rs2_data  in  XLEN  store data
in_rd_addr  in  5  destination register
in_funct3  in  3  funct3
in_wb_en  in  1  instruction writes rd
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_pc, out_inst, out_result, out_rs2_data, out_rd_addr, out_funct3, out_wb_en  out  (as in_*)  payload of oldest slot (slot DEPTH-1)
occupancy  out  $clog2(DEPTH+1)  number of valid slots
fwd_rs_addr  in  NUM_FWD*5  query register addresses, port k at [5k+4:5k]
fwd_hit  out  NUM_FWD  query k matched
fwd_data  out  NUM_FWD*XLEN  matched result, port k at [XLEN*k+XLEN-1:XLEN*k]

Behaviour:
- Slots 0..DEPTH-1. Slot 0 is youngest (entry); slot DEPTH-1 is oldest (exit). Each slot has a valid bit.
- Only the valid bits and occupancy are reset. Payload registers are not reset and load only when their slot captures.
- Reset (rst=1 at posedge): all valid bits 0, occupancy 0. out_valid=0 and fwd_hit=0 from the next cycle. Reset has priority over flush and input. Reset mid-stream drops all in-flight instructions with no output handshake.
- Advance rule: slot DEPTH-1 advances if it is empty or out_ready=1. Slot i<DEPTH-1 advances if slot i+1 is empty or slot i+1 advances.
- When a slot advances, it captures slot i-1 (slot 0 captures the input). A slot whose upstream is empty or not advancing becomes empty.
- Bubble collapsing: an empty slot always accepts, so stalled data compacts toward the exit.
- in_ready = advance(slot 0), combinational from out_ready and the valid bits. Upstream transfer occurs when in_valid & in_ready.
- out_valid = valid[DEPTH-1] & ~flush. Downstream transfer occurs when out_valid & out_ready.
- Timing: latency from input accept to out_valid is DEPTH cycles with no backpressure. Throughput is 1 per cycle when out_ready is held high.
- Full: occupancy=DEPTH and out_ready=0 gives in_ready=0, and payloads are held stable. Simultaneous out_ready=1 and in_valid=1 when full gives accept and emit in the same cycle, and occupancy stays DEPTH.
- Flush: at the posedge where flush=1, all valid bits clear and occupancy becomes 0. An input presented that cycle is discarded, even if in_ready=1. out_valid is forced 0 during the flush cycle, so no downstream transfer occurs.
- Occupancy: the registered count equals the popcount of the valid bits. It is updated +1 on accept only, -1 on emit only, and unchanged on both or neither.
- Forwarding for query k is purely combinational. Candidate slots are valid, wb_en=1, and rd_addr equal to the query.
  - fwd_hit[k]=1 if any slot is a candidate, and fwd_data[k] is the result of the lowest-index (youngest) candidate.
  - A query address of x0 never hits; fwd_data is 0 when there is no hit.
  - The flush input does not mask forwarding in the flush cycle.
- DEPTH=1 degenerates to a single register with an in_ready = ~valid | out_ready skid-free handshake.

Test Plan:
1. DEPTH=2, out_ready=1, accept pc=0x1000, result=0xDEAD_BEEF_0000_0001 at cycle 0 -> out_valid=1 with out_result=0xDEAD_BEEF_0000_0001 at cycle 2. Back-to-back inputs then emit one per cycle.
2. Fill with 2 entries while out_ready=0 -> occupancy=2, in_ready=0, out payload stable. Raise out_ready with in_valid=1 -> emit and accept in the same cycle, occupancy stays 2.
3. Accept an entry at cycle 0 with out_ready=0, then hold in_valid=0 -> the entry reaches slot 1 by cycle 2 (bubble collapse) and occupancy=1.
4. Occupancy=2, assert flush with in_valid=1 and out_ready=1 -> out_valid=0 that cycle. Next cycle occupancy=0 and out_valid=0, and the flush-cycle input never appears.
5. Forwarding: slot0 rd=5 result=0xAA, slot1 rd=5 result=0xBB, both wb_en=1, query 5 -> hit=1 with data=0xAA. Query 0 -> hit=0. Query 5 with slot0 wb_en=0 -> data=0xBB.
6. Assert rst with occupancy=2 and out_ready=0 -> next cycle occupancy=0, out_valid=0, fwd_hit=0. Rerun test 1 with XLEN=32, DEPTH=4 and expect latency of 4 cycles.

Source files
------------

// File: rtl/riscv_ex_pipe_slice.sv
// Elastic EX-to-EX pipeline slice: DEPTH payload slots with valid/ready
// backpressure, bubble collapsing, synchronous flush, an occupancy count
// and NUM_FWD combinational forwarding lookups into the in-flight results.
module riscv_ex_pipe_slice #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 2,
    parameter int NUM_FWD = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [31:0]                  in_inst,
    input  logic [XLEN-1:0]              in_result,
    input  logic [XLEN-1:0]              in_rs2_data,
    input  logic [4:0]                   in_rd_addr,
    input  logic [2:0]                   in_funct3,
    input  logic                         in_wb_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_inst,
    output logic [XLEN-1:0]              out_result,
    output logic [XLEN-1:0]              out_rs2_data,
    output logic [4:0]                   out_rd_addr,
    output logic [2:0]                   out_funct3,
    output logic                         out_wb_en,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic [NUM_FWD*5-1:0]         fwd_rs_addr,
    output logic [NUM_FWD-1:0]           fwd_hit,
    output logic [NUM_FWD*XLEN-1:0]      fwd_data
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic            wb_en;
    } payload_t;

    payload_t         slot_q   [DEPTH];
    payload_t         up_pl    [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] advance;
    logic             accept;
    logic             emit;

    // Each slot sees its upstream neighbour (slot 0 sees the input port).
    // A slot advances when any slot between it and the exit is empty or the
    // exit is draining; written flat so there is no combinational chain.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign up_valid[i] = in_valid;
            assign up_pl[i]    = '{pc: in_pc, inst: in_inst, result: in_result,
                                   rs2_data: in_rs2_data, rd_addr: in_rd_addr,
                                   funct3: in_funct3, wb_en: in_wb_en};
        end else begin : g_body
            assign up_valid[i] = valid_q[i-1];
            assign up_pl[i]    = slot_q[i-1];
        end
        if (i == DEPTH - 1) begin : g_exit
            assign advance[i] = out_ready | ~valid_q[i];
        end else begin : g_inner
            assign advance[i] = out_ready | ~(&valid_q[DEPTH-1:i+1]);
        end
    end

    assign in_ready     = advance[0];
    assign out_valid    = valid_q[DEPTH-1] & ~flush;
    assign accept       = in_valid & in_ready;
    assign emit         = out_valid & out_ready;

    assign out_pc       = slot_q[DEPTH-1].pc;
    assign out_inst     = slot_q[DEPTH-1].inst;
    assign out_result   = slot_q[DEPTH-1].result;
    assign out_rs2_data = slot_q[DEPTH-1].rs2_data;
    assign out_rd_addr  = slot_q[DEPTH-1].rd_addr;
    assign out_funct3   = slot_q[DEPTH-1].funct3;
    assign out_wb_en    = slot_q[DEPTH-1].wb_en;

    // Valid bits and occupancy: reset and flush both empty the slice;
    // otherwise advancing slots take their upstream valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            occupancy <= '0;
        end else if (flush) begin
            valid_q   <= '0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (advance[i]) begin
                    valid_q[i] <= up_valid[i];
                end
            end
            if (accept && !emit) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (emit && !accept) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    // Payload registers are never reset; a slot loads only when it captures
    // a valid upstream entry, so stalled payloads stay stable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (advance[i] && up_valid[i]) begin
                slot_q[i] <= up_pl[i];
            end
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins;
    // x0 never hits and flush deliberately does not mask the lookup.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (valid_q[i] && slot_q[i].wb_en &&
                    (fwd_rs_addr[5*k +: 5] != 5'd0) &&
                    (slot_q[i].rd_addr == fwd_rs_addr[5*k +: 5])) begin
                    fwd_hit[k]              = 1'b1;
                    fwd_data[XLEN*k +: XLEN] = slot_q[i].result;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_ex_pipe_slice.sv
// Self-checking bench for riscv_ex_pipe_slice: a DEPTH=2/XLEN=64 instance
// driven by directed vectors with a scoreboard on its output handshake, plus
// a DEPTH=4/XLEN=32 instance for the latency/throughput rerun.
module tb_riscv_ex_pipe_slice;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic [63:0] in_result;
    logic [63:0] in_rs2_data;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_funct3;
    logic        in_wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] out_result;
    logic [63:0] out_rs2_data;
    logic [4:0]  out_rd_addr;
    logic [2:0]  out_funct3;
    logic        out_wb_en;
    logic [1:0]  occupancy;
    logic [9:0]  fwd_rs_addr;
    logic [1:0]  fwd_hit;
    logic [127:0] fwd_data;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_pc;
    logic [31:0] b_in_inst;
    logic [31:0] b_in_result;
    logic [31:0] b_in_rs2_data;
    logic [4:0]  b_in_rd_addr;
    logic [2:0]  b_in_funct3;
    logic        b_in_wb_en;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_pc;
    logic [31:0] b_out_inst;
    logic [31:0] b_out_result;
    logic [31:0] b_out_rs2_data;
    logic [4:0]  b_out_rd_addr;
    logic [2:0]  b_out_funct3;
    logic        b_out_wb_en;
    logic [2:0]  b_occupancy;
    logic [4:0]  b_fwd_rs_addr;
    logic [0:0]  b_fwd_hit;
    logic [31:0] b_fwd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] result;
        logic [63:0] rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    riscv_ex_pipe_slice #(.XLEN(64), .DEPTH(2), .NUM_FWD(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_result(in_result),
        .in_rs2_data(in_rs2_data), .in_rd_addr(in_rd_addr),
        .in_funct3(in_funct3), .in_wb_en(in_wb_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_result(out_result),
        .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr),
        .out_funct3(out_funct3), .out_wb_en(out_wb_en),
        .occupancy(occupancy),
        .fwd_rs_addr(fwd_rs_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    riscv_ex_pipe_slice #(.XLEN(32), .DEPTH(4), .NUM_FWD(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pc(b_in_pc), .in_inst(b_in_inst), .in_result(b_in_result),
        .in_rs2_data(b_in_rs2_data), .in_rd_addr(b_in_rd_addr),
        .in_funct3(b_in_funct3), .in_wb_en(b_in_wb_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_inst(b_out_inst), .out_result(b_out_result),
        .out_rs2_data(b_out_rs2_data), .out_rd_addr(b_out_rd_addr),
        .out_funct3(b_out_funct3), .out_wb_en(b_out_wb_en),
        .occupancy(b_occupancy),
        .fwd_rs_addr(b_fwd_rs_addr), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then waits until
    // shortly before the falling edge so combinational outputs are settled.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic orr, input logic [63:0] pc,
                                 input logic [63:0] res, input logic [4:0] rd,
                                 input logic wb);
        @(posedge clk);
        #1;
        rst         = r;
        flush       = f;
        in_valid    = iv;
        out_ready   = orr;
        in_pc       = pc;
        in_result   = res;
        in_rs2_data = ~res;
        in_rd_addr  = rd;
        in_wb_en    = wb;
        #3;
    endtask

    // Scoreboard: accepted inputs are queued in order; every output handshake
    // pops and compares. Reset and flush discard everything in flight.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got pc=%0h, required no output", out_pc);
                end else begin
                    sb_e = sb_q.pop_front();
                    checkOutput("sb_pc", out_pc, sb_e.pc);
                    checkOutput("sb_result", out_result, sb_e.result);
                    checkOutput("sb_rs2", out_rs2_data, sb_e.rs2);
                    checkOutput("sb_rd", 64'(out_rd_addr), 64'(sb_e.rd));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{pc: in_pc, result: in_result, rs2: in_rs2_data, rd: in_rd_addr});
            end
        end
    end

    // Directed sequence following the test plan.
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = 32'h0000_0013; in_result = '0; in_rs2_data = '0;
        in_rd_addr = '0; in_funct3 = 3'b000; in_wb_en = 1'b0; fwd_rs_addr = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_pc = '0;
        b_in_inst = 32'h0000_0013; b_in_result = '0; b_in_rs2_data = '0;
        b_in_rd_addr = 5'd1; b_in_funct3 = 3'b000; b_in_wb_en = 1'b1; b_fwd_rs_addr = '0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        // Test 1: latency of 2, then back-to-back throughput
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h1000, 64'hDEAD_BEEF_0000_0001, 5'd1, 1'b1);
        checkOutput("t1_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t1_c0_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t1_c1_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t1_c2_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_c2_out_result", out_result, 64'hDEAD_BEEF_0000_0001);
        checkOutput("t1_c2_out_pc", out_pc, 64'h1000);
        for (int j = 0; j < 7; j++) begin
            applyStimulus(1'b0, 1'b0, (j < 4), 1'b1, 64'h1100 + 64'(4 * j),
                          64'h100 + 64'(j), 5'd2, 1'b1);
            if (j >= 2 && j < 6) begin
                checkOutput("t1_b2b_out_valid", 64'(out_valid), 64'd1);
                checkOutput("t1_b2b_out_result", out_result, 64'h100 + 64'(j - 2));
            end else if (j == 6) begin
                checkOutput("t1_drained_out_valid", 64'(out_valid), 64'd0);
            end
        end

        // Test 2: fill under backpressure, then simultaneous emit and accept
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h2000, 64'h20, 5'd3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h2004, 64'h21, 5'd3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h2008, 64'h22, 5'd3, 1'b1);
        checkOutput("t2_full_occupancy", 64'(occupancy), 64'd2);
        checkOutput("t2_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t2_full_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_full_out_pc", out_pc, 64'h2000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h2008, 64'h22, 5'd3, 1'b1);
        checkOutput("t2_stable_out_pc", out_pc, 64'h2000);
        checkOutput("t2_stable_out_result", out_result, 64'h20);
        checkOutput("t2_stable_occupancy", 64'(occupancy), 64'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h2008, 64'h22, 5'd3, 1'b1);
        checkOutput("t2_both_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t2_both_out_valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t2_after_occupancy", 64'(occupancy), 64'd2);
        checkOutput("t2_after_out_pc", out_pc, 64'h2004);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t2_drained_occupancy", 64'(occupancy), 64'd0);

        // Test 3: bubble collapse toward the exit
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h3000, 64'h30, 5'd4, 1'b1);
        checkOutput("t3_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t3_c1_occupancy", 64'(occupancy), 64'd1);
        checkOutput("t3_c1_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t3_c2_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_c2_out_pc", out_pc, 64'h3000);
        checkOutput("t3_c2_occupancy", 64'(occupancy), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t3_drained_occupancy", 64'(occupancy), 64'd0);

        // Test 4: flush kills in-flight entries and the flush-cycle input
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h4000, 64'h40, 5'd5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h4004, 64'h41, 5'd5, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h4008, 64'h42, 5'd5, 1'b1);
        checkOutput("t4_flush_occupancy", 64'(occupancy), 64'd2);
        checkOutput("t4_flush_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t4_post_occupancy", 64'(occupancy), 64'd0);
        checkOutput("t4_post_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t4_post2_out_valid", 64'(out_valid), 64'd0);

        // Test 5: forwarding picks the youngest writer, x0 never hits
        fwd_rs_addr = {5'd0, 5'd5};
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h5000, 64'hBB, 5'd5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h5004, 64'hAA, 5'd5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t5_hit0", 64'(fwd_hit[0]), 64'd1);
        checkOutput("t5_data0_young", fwd_data[63:0], 64'hAA);
        checkOutput("t5_hit1_x0", 64'(fwd_hit[1]), 64'd0);
        checkOutput("t5_data1_x0", fwd_data[127:64], 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t5_flush_hit0", 64'(fwd_hit[0]), 64'd1);
        checkOutput("t5_flush_data0", fwd_data[63:0], 64'hAA);
        fwd_rs_addr = {5'd6, 5'd5};
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h5008, 64'hBB, 5'd5, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h500C, 64'hAA, 5'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t5_nowb_hit0", 64'(fwd_hit[0]), 64'd1);
        checkOutput("t5_nowb_data0", fwd_data[63:0], 64'hBB);
        checkOutput("t5_miss_hit1", 64'(fwd_hit[1]), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t5_empty_hit", 64'(fwd_hit), 64'd0);

        // Test 6: reset mid-stream drops everything
        fwd_rs_addr = {5'd0, 5'd7};
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h6000, 64'h60, 5'd7, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h6004, 64'h61, 5'd7, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t6_pre_occupancy", 64'(occupancy), 64'd2);
        checkOutput("t6_pre_hit0", 64'(fwd_hit[0]), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        checkOutput("t6_post_occupancy", 64'(occupancy), 64'd0);
        checkOutput("t6_post_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_post_hit", 64'(fwd_hit), 64'd0);
        fwd_rs_addr = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0);

        // XLEN=32, DEPTH=4 rerun: latency 4, then one result per cycle
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            b_in_valid    = (c < 4);
            b_in_pc       = 32'h1000 + 32'(4 * c);
            b_in_result   = 32'hDEAD_0001 + 32'(c);
            b_in_rs2_data = 32'h0;
            #3;
            if (c == 0) begin
                checkOutput("b_in_ready", 64'(b_in_ready), 64'd1);
            end
            if (c < 4) begin
                checkOutput("b_latency_out_valid", 64'(b_out_valid), 64'd0);
            end else if (c < 8) begin
                checkOutput("b_stream_out_valid", 64'(b_out_valid), 64'd1);
                checkOutput("b_stream_out_result", 64'(b_out_result),
                            64'(32'hDEAD_0001 + 32'(c - 4)));
            end else begin
                checkOutput("b_drained_out_valid", 64'(b_out_valid), 64'd0);
            end
        end

        checkOutput("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
